// File: rtl/digit_scan_ctrl_pkg.sv
// Shared slot-scan definitions: slot count, select width, slot code encodings.
// Pure declarations, no logic latency.
// No flow control; consumed by the scan controller and decoder benches.
package digit_scan_ctrl_pkg;

  localparam int SLOT_N = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [SLOT_N-1:0] mask_t;

  // Slot code encodings as seen on the decoder select pins {x1,x0}
  localparam sel_t SLOT_0 = 2'd0;
  localparam sel_t SLOT_1 = 2'd1;
  localparam sel_t SLOT_2 = 2'd2;
  localparam sel_t SLOT_3 = 2'd3;

  // Circular step: slot s advanced by k positions, wrapping modulo SLOT_N
  function automatic sel_t sel_step(input sel_t s, input int k);
    return s + sel_t'(k);
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_rr_next_slot.sv
// Round-robin successor: first enabled slot after cur_sel, circularly, falling back to cur_sel.
// Purely combinational, zero latency.
// No flow control; caller decides when to take next_sel.
module rr_next_slot
  import digit_scan_ctrl_pkg::*;
(
  input  logic [SEL_W-1:0]  cur_sel,
  input  logic [SLOT_N-1:0] mask,
  output logic [SEL_W-1:0]  next_sel,
  output logic              wrap,
  output logic              none
);

  // Search cur_sel+1 .. cur_sel+SLOT_N; the last candidate is cur_sel itself
  always_comb begin
    sel_t cand;
    logic found;
    cand     = cur_sel;
    found    = 1'b0;
    next_sel = cur_sel;
    for (int k = 1; k <= SLOT_N; k++) begin
      cand = sel_step(cur_sel, k);
      if (!found && mask[cand]) begin
        next_sel = cand;
        found    = 1'b1;
      end
    end
  end

  // A move that does not go numerically upward closes a frame (includes staying put)
  assign none = ~|mask;
  assign wrap = ~none & (next_sel <= cur_sel);

endmodule

// File: rtl/digit_scan_ctrl.sv
// Digit scan select generator: steps {x1,x0} through enabled slots every PRESCALE enabled clocks.
// Latency 1: all outputs registered, new slot visible the cycle after the terminal-count cycle.
// No backpressure; enable=0 freezes prescaler and slot and blanks the consumer.
module digit_scan_ctrl
  import digit_scan_ctrl_pkg::*;
#(
  parameter int PRESCALE   = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [SLOT_N-1:0] slot_mask,
  input  logic              force_en,
  input  logic [SEL_W-1:0]  force_sel,
  output logic              x1,
  output logic              x0,
  output logic              blank,
  output logic              slot_tick,
  output logic              frame_done
);

  localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(PRESCALE - 1);
  localparam logic [PRESCALE_W-1:0] PRESC_ONE  = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  sel_t                  sel_q, sel_d;
  logic                  blank_q, blank_d;
  logic                  slot_tick_q, slot_tick_d;
  logic                  frame_done_q, frame_done_d;

  sel_t next_sel;
  logic wrap;
  logic none;
  logic term_cnt;

  rr_next_slot u_rr_next_slot (
    .cur_sel  (sel_q),
    .mask     (slot_mask),
    .next_sel (next_sel),
    .wrap     (wrap),
    .none     (none)
  );

  assign term_cnt = enable && (presc_q == PRESC_LAST);

  // Next state: force beats prescaler advance; an empty mask still lets the prescaler run
  always_comb begin
    presc_d      = presc_q;
    sel_d        = sel_q;
    slot_tick_d  = 1'b0;
    frame_done_d = 1'b0;
    blank_d      = ~enable | none;
    if (force_en) begin
      sel_d   = force_sel;
      presc_d = '0;
    end else if (enable) begin
      if (term_cnt) begin
        presc_d = '0;
        if (!none) begin
          sel_d        = next_sel;
          slot_tick_d  = 1'b1;
          frame_done_d = wrap;
        end
      end else begin
        presc_d = presc_q + PRESC_ONE;
      end
    end
  end

  // State and output registers, cleared immediately by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q      <= '0;
      sel_q        <= SLOT_0;
      blank_q      <= 1'b1;
      slot_tick_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      sel_q        <= sel_d;
      blank_q      <= blank_d;
      slot_tick_q  <= slot_tick_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign x1         = sel_q[1];
  assign x0         = sel_q[0];
  assign blank      = blank_q;
  assign slot_tick  = slot_tick_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
module tb_digit_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] slot_mask;
  logic       force_en;
  logic [1:0] force_sel;
  logic       x1, x0, blank, slot_tick, frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  digit_scan_ctrl #(.PRESCALE(4), .PRESCALE_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .slot_mask  (slot_mask),
    .force_en   (force_en),
    .force_sel  (force_sel),
    .x1         (x1),
    .x0         (x0),
    .blank      (blank),
    .slot_tick  (slot_tick),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] mask;
    logic       fe;
    logic [1:0] fs;
    logic [1:0] sel;
    logic       blank;
    logic       tick;
    logic       frame;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, input logic [3:0] mask, input logic fe,
                              input logic [1:0] fs, input logic [1:0] sel, input logic bl,
                              input logic tick, input logic frame);
    vec_t v;
    v.en = en; v.mask = mask; v.fe = fe; v.fs = fs;
    v.sel = sel; v.blank = bl; v.tick = tick; v.frame = frame;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sample after each rising edge until a slot_tick appears; cnt = edges taken (17 = timed out)
  task automatic wait_tick(output int cnt);
    bit seen;
    seen = 1'b0;
    cnt  = 0;
    while (!seen && cnt < 17) begin
      @(posedge clk); #1;
      cnt++;
      if (slot_tick === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] sel, input logic bl,
                           input logic tick, input logic frame);
    check({tag, " sel"},   {2'b00, x1, x0},    {2'b00, sel});
    check({tag, " blank"}, {3'b000, blank},     {3'b000, bl});
    check({tag, " tick"},  {3'b000, slot_tick}, {3'b000, tick});
    check({tag, " frame"}, {3'b000, frame_done},{3'b000, frame});
  endtask

  initial begin
    int cnt;
    logic [1:0] s;

    // Full rotation, mask 1111: advance every 4th edge, frame only on 3->0
    for (int n = 1; n <= 20; n++)
      add(1'b1, 4'b1111, 1'b0, 2'd0, 2'((n / 4) % 4), 1'b0, (n % 4) == 0, n == 16);
    // mask 1010 from slot 1: 1 -> 3 -> 1 ..., frame on each 3->1
    for (int n = 1; n <= 16; n++) begin
      s = (n < 4) ? 2'd1 : (((n / 4) % 2) == 1 ? 2'd3 : 2'd1);
      add(1'b1, 4'b1010, 1'b0, 2'd0, s, 1'b0, (n % 4) == 0, ((n % 4) == 0) && (s == 2'd1));
    end
    // Empty mask: blank next cycle, slot frozen, prescaler wraps silently
    for (int n = 1; n <= 6; n++) add(1'b1, 4'b0000, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 4'b0100, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 4'b0100, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0);
    // Enable low mid-dwell: hold, blank, resume from held count
    add(1'b1, 4'b1111, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    add(1'b1, 4'b1111, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 3; n++) add(1'b0, 4'b1111, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0);
    add(1'b1, 4'b1111, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    add(1'b1, 4'b1111, 1'b0, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0);
    add(1'b1, 4'b1111, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    // Force mid-dwell, then advance exactly 4 cycles later
    add(1'b1, 4'b1111, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    add(1'b1, 4'b1111, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 3; n++) add(1'b1, 4'b1111, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    add(1'b1, 4'b1111, 1'b0, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0);
    // Force on the terminal-count cycle wins, no pulse
    for (int n = 1; n <= 3; n++) add(1'b1, 4'b1111, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    add(1'b1, 4'b1111, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 3; n++) add(1'b1, 4'b1111, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 4'b1111, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0);
    // Force while disabled to a masked-off slot; left at next terminal count
    add(1'b0, 4'b0010, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int n = 1; n <= 3; n++) add(1'b1, 4'b0010, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 4'b0010, 1'b0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0);
    // Single-slot mask: code stays 0, tick and frame every 4 cycles
    add(1'b1, 4'b0001, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int n = 1; n <= 3; n++) add(1'b1, 4'b0001, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 4'b0001, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    end

    reset = 1'b1; enable = 1'b0; slot_mask = 4'b0000; force_en = 1'b0; force_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 2'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      enable = vecs[i].en; slot_mask = vecs[i].mask;
      force_en = vecs[i].fe; force_sel = vecs[i].fs;
      @(posedge clk); #1;
      check_all($sformatf("row%0d", i), vecs[i].sel, vecs[i].blank, vecs[i].tick, vecs[i].frame);
    end

    // Reset asserted mid-dwell at slot 3 clears outputs before the next edge
    @(negedge clk); enable = 1'b1; slot_mask = 4'b1111; force_en = 1'b1; force_sel = 2'd3;
    @(negedge clk); force_en = 1'b0;
    @(posedge clk); #1;
    check("pre-reset sel", {2'b00, x1, x0}, 4'd3);
    #2 reset = 1'b1;
    #1;
    check_all("async reset", 2'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b0;
    wait_tick(cnt);
    check("post-reset tick delay", cnt[3:0], 4'd4);
    check("post-reset sel", {2'b00, x1, x0}, 4'd1);

    // mask 1010 from reset: 0 -> 1 -> 3 -> 1
    @(negedge clk); reset = 1'b1; slot_mask = 4'b1010;
    @(negedge clk); reset = 1'b0;
    wait_tick(cnt);
    check("1010 first delay", cnt[3:0], 4'd4);
    check("1010 first sel", {2'b00, x1, x0}, 4'd1);
    check("1010 first frame", {3'b000, frame_done}, 4'd0);
    wait_tick(cnt);
    check("1010 second sel", {2'b00, x1, x0}, 4'd3);
    wait_tick(cnt);
    check("1010 third sel", {2'b00, x1, x0}, 4'd1);
    check("1010 third frame", {3'b000, frame_done}, 4'd1);

    // Force to 2 at prescaler=2 while at slot 0, then advance to 3 four cycles later
    @(negedge clk); reset = 1'b1; slot_mask = 4'b1111;
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); force_en = 1'b1; force_sel = 2'd2;
    @(posedge clk); #1;
    check("force sel", {2'b00, x1, x0}, 4'd2);
    check("force tick", {3'b000, slot_tick}, 4'd0);
    @(negedge clk); force_en = 1'b0;
    wait_tick(cnt);
    check("force follow delay", cnt[3:0], 4'd4);
    check("force follow sel", {2'b00, x1, x0}, 4'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
